// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Adds or subtracts two WIDTH-bit operands through one shared 4-bit adder
//   slice. It processes one nibble per cycle, starting with the LSB nibble.
//   A register carries the carry from one nibble to the next. A
//   valid/ready handshake on the operand side and on the result side hands
//   data in and out. Subtraction is done as A + ~B + 1: B is inverted when
//   it is latched, and the carry register is seeded with 1.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            asynchronous reset, active-high
//   i_in_valid       operand bundle valid
//   o_in_ready       controller can accept operands (IDLE)
//   i_in_a, i_in_b   operands, WIDTH bits
//   i_in_sub         1 = A-B, 0 = A+B
//   o_out_valid      result valid (DONE)
//   i_out_ready      consumer accepts result
//   o_out_sum        result bits, WIDTH bits
//   o_out_carry      carry out of MSB (for subtraction, 1 = no borrow)
//   o_out_overflow   signed two's-complement overflow
//   o_busy           high while nibbles are being processed (RUN)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one nibble per cycle through the shared adder slice
// DONE  | result held until the consumer accepts it

module adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [4:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    assign o_sum  = w_full[3:0];
    assign o_cout = w_full[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    input  logic             i_in_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_sum,
    output logic             o_out_carry,
    output logic             o_out_overflow,
    output logic             o_busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;
    logic             r_ovf;

    logic [3:0] w_nib_a;
    logic [3:0] w_nib_b;
    logic [3:0] w_nib_sum;
    logic       w_nib_cout;
    logic       w_c_into_msb;
    logic       w_last;

    assign w_nib_a = r_a[4*r_idx +: 4];
    assign w_nib_b = r_b[4*r_idx +: 4];
    assign w_last  = (r_idx == LAST_IDX);

    adder_4bit u_adder (
        .i_a    (w_nib_a),
        .i_b    (w_nib_b),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    // The carry into the top bit of a nibble can be recovered from that
    // bit's inputs and its sum bit. Here b is the already-inverted operand.
    assign w_c_into_msb = w_nib_a[3] ^ w_nib_b[3] ^ w_nib_sum[3];

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_in_valid) w_state_nxt = RUN;
            RUN:     if (w_last)     w_state_nxt = DONE;
            DONE:    if (i_out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state
    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            IDLE:    o_in_ready  = 1'b1;
            RUN:     o_busy      = 1'b1;
            DONE:    o_out_valid = 1'b1;
            default: o_in_ready  = 1'b0;
        endcase
    end

    // Datapath
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_in_a;
                        r_b     <= i_in_b ^ {WIDTH{i_in_sub}};
                        r_carry <= i_in_sub;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[4*r_idx +: 4] <= w_nib_sum;
                    r_carry             <= w_nib_cout;
                    if (w_last) begin
                        r_carry_out <= w_nib_cout;
                        r_ovf       <= w_c_into_msb ^ w_nib_cout;
                        r_idx       <= '0;
                    end else begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_out_sum      = r_sum;
    assign o_out_carry    = r_carry_out;
    assign o_out_overflow = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_overflow;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_a         (in_a),
        .i_in_b         (in_b),
        .i_in_sub       (in_sub),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_sum      (out_sum),
        .o_out_carry    (out_carry),
        .o_out_overflow (out_overflow),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on the whole word, plus the signed
    // overflow rule based on operand and result signs.
    function automatic logic [W+1:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sub);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         ovf;
        if (sub) full = {1'b0, a} + {1'b0, ~b} + 1;
        else     full = {1'b0, a} + {1'b0, b};
        s = full[W-1:0];
        if (sub) ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        else     ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {ovf, full[W], s};
    endfunction

    // One full operation. Inputs are driven and outputs sampled on the
    // falling edge. hold = cycles with out_ready low after the result
    // appears. With junk set, random bundles are offered while busy.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input int hold, input bit junk, input string tag);
        logic [W+1:0] exp;
        exp = ref_calc(a, b, sub);
        check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        out_ready = 1'b0;
        for (int i = 1; i <= NIB; i++) begin
            @(negedge clk);
            if (junk) begin
                in_valid = 1'b1;
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_sub   = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (i < NIB) begin
                check({tag, ":run_valid"}, 32'(out_valid), 32'd0);
                check({tag, ":run_in_ready"}, 32'(in_ready), 32'd0);
                check({tag, ":run_busy"}, 32'(busy), 32'd1);
            end
        end
        @(negedge clk);
        check({tag, ":out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ":busy_done"}, 32'(busy), 32'd0);
        check({tag, ":sum"}, 32'(out_sum), 32'(exp[W-1:0]));
        check({tag, ":carry"}, 32'(out_carry), 32'(exp[W]));
        check({tag, ":ovf"}, 32'(out_overflow), 32'(exp[W+1]));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            @(negedge clk);
            check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ":hold_sum"}, 32'(out_sum), 32'(exp[W-1:0]));
            check({tag, ":hold_flags"}, 32'({out_carry, out_overflow}), 32'(exp[W+1:W] >> 0) == 32'(exp[W+1:W]) ? 32'({exp[W], exp[W+1]}) : 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":released_valid"}, 32'(out_valid), 32'd0);
        check({tag, ":released_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset:in_ready", 32'(in_ready), 32'd1);
        check("reset:out_valid", 32'(out_valid), 32'd0);
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:outs", 32'({out_sum, out_carry, out_overflow}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'h1234, 16'h0FFF, 1'b0, 0, 1'b0, "add_1234_0fff");
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "add_ffff_0001");
        do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, "add_7fff_0001");
        do_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0, "sub_8000_0001");
        do_op(16'h0003, 16'h0005, 1'b1, 0, 1'b0, "sub_0003_0005");
        do_op(16'hA5A5, 16'h5A5A, 1'b0, 5, 1'b0, "hold5");
        do_op(16'h4321, 16'h1111, 1'b1, 1, 1'b1, "junk_run");
        do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0, "sub_zero");
        do_op(16'h0000, 16'h8000, 1'b1, 0, 1'b0, "sub_0_8000");

        // Reset during the second RUN cycle, then a clean operation.
        in_valid = 1'b1;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        in_sub   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst:in_ready", 32'(in_ready), 32'd1);
        check("midrst:out_valid", 32'(out_valid), 32'd0);
        check("midrst:busy", 32'(busy), 32'd0);
        check("midrst:outs", 32'({out_sum, out_carry, out_overflow}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(16'h00F0, 16'h0F0F, 1'b0, 0, 1'b0, "after_rst");

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 8 == 0) ra = 16'h8000;
            if (n % 8 == 1) rb = 16'h7FFF;
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
